// File: rtl/dmux4way16_fifo.sv
// Registered 4-way 16-bit demultiplexer with a 2-entry FIFO per lane.
// One producer, four independent consumers; a full lane stalls only its own pushes.
module dmux4way16_fifo (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic [1:0]  in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [15:0] c,
    output logic [15:0] d,
    output logic [3:0]  out_valid,
    input  logic [3:0]  out_ready
);

    logic [3:0][1:0]  cnt_q;
    logic [3:0][15:0] head;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready = (cnt_q[in_sel] != 2'd2);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [1:0][15:0] mem;
        logic             wp;
        logic             rp;
        logic [1:0]       cnt;
        logic             push;
        logic             pop;

        assign push         = in_valid && in_ready && (in_sel == 2'(i));
        assign pop          = out_valid[i] && out_ready[i];
        assign out_valid[i] = (cnt != 2'd0);
        assign cnt_q[i]     = cnt;
        assign head[i]      = out_valid[i] ? mem[rp] : 16'h0000;

        always_ff @(posedge clk) begin
            if (reset) begin
                mem <= '0;
                wp  <= 1'b0;
                rp  <= 1'b0;
                cnt <= 2'd0;
            end else begin
                if (push) begin
                    mem[wp] <= in;
                    wp      <= ~wp;
                end
                if (pop) begin
                    rp <= ~rp;
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + 2'd1;
                    2'b01:   cnt <= cnt - 2'd1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign a = head[0];
    assign b = head[1];
    assign c = head[2];
    assign d = head[3];

endmodule

// File: tb/tb_dmux4way16_fifo.sv
// Self-checking bench for dmux4way16_fifo: queue model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dmux4way16_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [15:0] q [4][$];

    dmux4way16_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    // Model: each lane is a queue of at most two words.
    always @(posedge clk) begin : model
        bit do_push;
        if (reset) begin
            for (int i = 0; i < 4; i++) q[i].delete();
        end else begin
            do_push = in_valid && (q[in_sel].size() < 2);
            for (int i = 0; i < 4; i++)
                if (out_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
            if (do_push) q[in_sel].push_back(in);
        end
    end

    function automatic logic [15:0] exp_head(input int i);
        return (q[i].size() > 0) ? q[i][0] : 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] ev;
            for (int i = 0; i < 4; i++) ev[i] = (q[i].size() > 0);
            chk("model_out_valid", {12'h0, out_valid}, {12'h0, ev});
            chk("model_a", a, exp_head(0));
            chk("model_b", b, exp_head(1));
            chk("model_c", c, exp_head(2));
            chk("model_d", d, exp_head(3));
            chk("model_in_ready", {15'h0, in_ready},
                {15'h0, q[in_sel].size() != 2});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in        = 16'h0;
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 4'b0;

        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {12'h0, out_valid}, 16'h0);
        chk("rst_a", a, 16'h0);
        chk("rst_b", b, 16'h0);
        chk("rst_c", c, 16'h0);
        chk("rst_d", d, 16'h0);
        for (int s = 0; s < 4; s++) begin
            step();
            in_sel = 2'(s);
            #1;
            chk("rst_in_ready", {15'h0, in_ready}, 16'h1);
        end

        // Single route to lane c
        step();
        in_valid = 1'b1; in_sel = 2'd2; in = 16'h1234;
        step();
        in_valid = 1'b0;
        #1;
        chk("route_valid", {12'h0, out_valid}, 16'h0004);
        chk("route_c", c, 16'h1234);
        chk("route_a", a, 16'h0);
        chk("route_d", d, 16'h0);
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0;
        #1;
        chk("route_pop_valid", {12'h0, out_valid}, 16'h0);
        chk("route_pop_c", c, 16'h0);

        // Fill lane a, back-pressure only lane a
        step();
        in_valid = 1'b1; in_sel = 2'd0; in = 16'hAAAA;
        step();
        in = 16'hBBBB;
        step();
        in_valid = 1'b0;
        #1;
        chk("full_ready_a", {15'h0, in_ready}, 16'h0);
        in_sel = 2'd1;
        #1;
        chk("full_ready_b", {15'h0, in_ready}, 16'h1);
        in_valid = 1'b1; in = 16'hCCCC;
        step();
        in_valid = 1'b0;
        #1;
        chk("other_lane_b", b, 16'hCCCC);
        chk("fifo_first", a, 16'hAAAA);
        out_ready = 4'b0001;
        step();
        #1;
        chk("fifo_second", a, 16'hBBBB);
        step();
        out_ready = 4'b0010;
        #1;
        chk("fifo_drained", {15'h0, out_valid[0]}, 16'h0);
        step();
        out_ready = 4'b0;

        // Streaming through lane d
        out_ready = 4'b1000;
        for (int k = 1; k <= 16; k++) begin
            step();
            in_valid = 1'b1; in_sel = 2'd3; in = 16'(k);
            #1;
            chk("stream_ready", {15'h0, in_ready}, 16'h1);
            if (k > 1) chk("stream_d", d, 16'(k - 1));
        end
        step();
        in_valid = 1'b0;
        #1;
        chk("stream_last", d, 16'h0010);
        step();
        out_ready = 4'b0;
        #1;
        chk("stream_empty", {12'h0, out_valid}, 16'h0);

        // Push and pop on a full lane b
        step();
        in_valid = 1'b1; in_sel = 2'd1; in = 16'h0011;
        step();
        in = 16'h0022;
        step();
        in = 16'h0033; out_ready = 4'b0010;
        #1;
        chk("full_pp_ready", {15'h0, in_ready}, 16'h0);
        chk("full_pp_head", b, 16'h0011);
        step();
        #1;
        chk("full_pp_adv", b, 16'h0022);
        chk("full_pp_ready2", {15'h0, in_ready}, 16'h1);
        step();
        in_valid = 1'b0;
        #1;
        chk("full_pp_next", b, 16'h0033);
        step();
        out_ready = 4'b0;
        #1;
        chk("full_pp_empty", {15'h0, out_valid[1]}, 16'h0);

        // Reset while lanes a and d are full, with a push and a pop pending
        step();
        in_valid = 1'b1; in_sel = 2'd0; in = 16'hA001;
        step();
        in = 16'hA002;
        step();
        in_sel = 2'd3; in = 16'hD001;
        step();
        in = 16'hD002;
        step();
        in_sel = 2'd1; in = 16'hBEEF; out_ready = 4'b0001; reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 4'b0;
        #1;
        chk("mid_rst_valid", {12'h0, out_valid}, 16'h0);
        chk("mid_rst_a", a, 16'h0);
        chk("mid_rst_b", b, 16'h0);
        chk("mid_rst_d", d, 16'h0);
        step();
        step();
        #1;
        chk("mid_rst_idle", {12'h0, out_valid}, 16'h0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
